// File: rtl/id_stage_pipe_pkg.sv
//==============================================================================
// Module      : id_stage_pipe_pkg
// Description : Shared definitions for the MIPS ID stage: default widths,
//               opcode/funct constants, ALU operation encodings and the
//               decoded-control bundle passed from the decoder to the top.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package id_stage_pipe_pkg;

    // Default widths
    localparam int unsigned c_DATA_W  = 32;
    localparam int unsigned c_REG_AW  = 5;
    localparam int unsigned c_ALUOP_W = 4;
    localparam int unsigned c_PC_W    = 32;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_XORI  = 6'h0E;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    // R-type function codes (inst[5:0])
    localparam logic [5:0] c_FN_SLL  = 6'h00;
    localparam logic [5:0] c_FN_SRL  = 6'h02;
    localparam logic [5:0] c_FN_ADDU = 6'h21;
    localparam logic [5:0] c_FN_SUBU = 6'h23;
    localparam logic [5:0] c_FN_AND  = 6'h24;
    localparam logic [5:0] c_FN_OR   = 6'h25;
    localparam logic [5:0] c_FN_XOR  = 6'h26;
    localparam logic [5:0] c_FN_SLT  = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } alu_op_e;

    // Source of operand 2: register (NONE) or one of the immediate forms
    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_SEXT = 2'd1,
        IMM_ZEXT = 2'd2,
        IMM_LUI  = 2'd3
    } imm_sel_e;

    // Destination register field
    typedef enum logic [1:0] {
        WR_NONE = 2'd0,
        WR_RD   = 2'd1,
        WR_RT   = 2'd2
    } wr_sel_e;

    typedef struct packed {
        alu_op_e  alu_op;
        imm_sel_e imm_sel;
        logic     rd_en1;
        logic     rd_en2;
        wr_sel_e  wr_sel;
        logic     shift;     // op1 comes from the shamt field
        logic     mem_rd;
        logic     mem_wr;
        logic     br_eq;
        logic     br_ne;
        logic     illegal;
    } dec_t;

endpackage

`default_nettype wire

// File: rtl/id_stage_pipe_if.sv
//==============================================================================
// Module      : id_stage_pipe_if
// Description : Bundle of every ID-stage signal except clk/rst: the IF-side
//               handshake, register-file read port, EX/MEM forwarding
//               sources, flush, and the ID/EX pipeline register outputs.
//               master = ID stage, slave = surrounding pipeline.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface id_stage_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4,
    parameter int PC_W    = 32
);
    // IF side
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_inst;
    logic [PC_W-1:0]    in_pc;
    // Register file
    logic [REG_AW-1:0]  rd_addr1;
    logic [REG_AW-1:0]  rd_addr2;
    logic               rd_en1;
    logic               rd_en2;
    logic [DATA_W-1:0]  rd_data1;
    logic [DATA_W-1:0]  rd_data2;
    // Forwarding sources and hazard info
    logic               ex_wr_en;
    logic [REG_AW-1:0]  ex_wr_addr;
    logic [DATA_W-1:0]  ex_wr_data;
    logic               ex_is_load;
    logic               mem_wr_en;
    logic [REG_AW-1:0]  mem_wr_addr;
    logic [DATA_W-1:0]  mem_wr_data;
    logic               flush;
    // ID/EX register
    logic               out_valid;
    logic               out_ready;
    logic [ALUOP_W-1:0] out_alu_op;
    logic [DATA_W-1:0]  out_op1;
    logic [DATA_W-1:0]  out_op2;
    logic [DATA_W-1:0]  out_st_data;
    logic [REG_AW-1:0]  out_wr_addr;
    logic               out_wr_en;
    logic               out_mem_rd;
    logic               out_mem_wr;
    logic               out_br_taken;
    logic [PC_W-1:0]    out_br_target;
    logic               out_illegal;

    modport master (
        input  in_valid, in_inst, in_pc, rd_data1, rd_data2,
               ex_wr_en, ex_wr_addr, ex_wr_data, ex_is_load,
               mem_wr_en, mem_wr_addr, mem_wr_data, flush, out_ready,
        output in_ready, rd_addr1, rd_addr2, rd_en1, rd_en2,
               out_valid, out_alu_op, out_op1, out_op2, out_st_data,
               out_wr_addr, out_wr_en, out_mem_rd, out_mem_wr,
               out_br_taken, out_br_target, out_illegal
    );

    modport slave (
        output in_valid, in_inst, in_pc, rd_data1, rd_data2,
               ex_wr_en, ex_wr_addr, ex_wr_data, ex_is_load,
               mem_wr_en, mem_wr_addr, mem_wr_data, flush, out_ready,
        input  in_ready, rd_addr1, rd_addr2, rd_en1, rd_en2,
               out_valid, out_alu_op, out_op1, out_op2, out_st_data,
               out_wr_addr, out_wr_en, out_mem_rd, out_mem_wr,
               out_br_taken, out_br_target, out_illegal
    );

endinterface

`default_nettype wire

// File: rtl/id_stage_pipe_decoder.sv
//==============================================================================
// Module      : id_stage_pipe_decoder
// Description : Combinational MIPS decoder, opcode/funct -> control bundle.
//               Unsupported encodings decode as a NOP with illegal set.
//   i_opcode  in  6   inst[31:26]
//   i_funct   in  6   inst[5:0]
//   o_dec     out     decoded control (dec_t)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module id_stage_pipe_decoder
    import id_stage_pipe_pkg::*;
(
    input  wire logic [5:0] i_opcode,
    input  wire logic [5:0] i_funct,
    output dec_t            o_dec
);

    always_comb begin
        o_dec         = '0;
        o_dec.alu_op  = ALU_ADD;
        o_dec.imm_sel = IMM_NONE;
        o_dec.wr_sel  = WR_NONE;

        case (i_opcode)
            c_OP_RTYPE: begin
                o_dec.rd_en1 = 1'b1;
                o_dec.rd_en2 = 1'b1;
                o_dec.wr_sel = WR_RD;
                case (i_funct)
                    c_FN_ADDU: o_dec.alu_op = ALU_ADD;
                    c_FN_SUBU: o_dec.alu_op = ALU_SUB;
                    c_FN_AND:  o_dec.alu_op = ALU_AND;
                    c_FN_OR:   o_dec.alu_op = ALU_OR;
                    c_FN_XOR:  o_dec.alu_op = ALU_XOR;
                    c_FN_SLT:  o_dec.alu_op = ALU_SLT;
                    c_FN_SLL, c_FN_SRL: begin
                        // Shifts take shamt as op1; rs is not read
                        o_dec.alu_op = (i_funct == c_FN_SLL) ? ALU_SLL : ALU_SRL;
                        o_dec.rd_en1 = 1'b0;
                        o_dec.shift  = 1'b1;
                    end
                    default: begin
                        o_dec.rd_en1  = 1'b0;
                        o_dec.rd_en2  = 1'b0;
                        o_dec.wr_sel  = WR_NONE;
                        o_dec.illegal = 1'b1;
                    end
                endcase
            end
            c_OP_ADDIU, c_OP_SLTI, c_OP_LW: begin
                o_dec.alu_op  = (i_opcode == c_OP_SLTI) ? ALU_SLT : ALU_ADD;
                o_dec.imm_sel = IMM_SEXT;
                o_dec.rd_en1  = 1'b1;
                o_dec.wr_sel  = WR_RT;
                o_dec.mem_rd  = (i_opcode == c_OP_LW);
            end
            c_OP_ANDI, c_OP_ORI, c_OP_XORI: begin
                o_dec.alu_op  = (i_opcode == c_OP_ANDI) ? ALU_AND :
                                (i_opcode == c_OP_ORI)  ? ALU_OR  : ALU_XOR;
                o_dec.imm_sel = IMM_ZEXT;
                o_dec.rd_en1  = 1'b1;
                o_dec.wr_sel  = WR_RT;
            end
            c_OP_LUI: begin
                // op1 is forced to zero, so ADD passes imm<<16 through
                o_dec.imm_sel = IMM_LUI;
                o_dec.wr_sel  = WR_RT;
            end
            c_OP_SW: begin
                o_dec.imm_sel = IMM_SEXT;
                o_dec.rd_en1  = 1'b1;
                o_dec.rd_en2  = 1'b1;
                o_dec.mem_wr  = 1'b1;
            end
            c_OP_BEQ, c_OP_BNE: begin
                o_dec.alu_op = ALU_SUB;
                o_dec.rd_en1 = 1'b1;
                o_dec.rd_en2 = 1'b1;
                o_dec.br_eq  = (i_opcode == c_OP_BEQ);
                o_dec.br_ne  = (i_opcode == c_OP_BNE);
            end
            default: o_dec.illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/id_stage_pipe.sv
//==============================================================================
// Module      : id_stage_pipe
// Description : Registered MIPS decode stage between IF and EX. Decodes the
//               instruction, reads the register file, forwards EX/MEM
//               results, stalls on load-use, resolves BEQ/BNE and drives the
//               ID/EX register with a valid/ready handshake (1-cycle latency).
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset
//   bus  id_stage_pipe_if.master - IF handshake, regfile port, forwarding
//        sources, flush and ID/EX outputs
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int REG_AW  = c_REG_AW,
    parameter int ALUOP_W = c_ALUOP_W,
    parameter int PC_W    = c_PC_W
) (
    input wire logic        clk,
    input wire logic        rst,
    id_stage_pipe_if.master bus
);

    logic [31:0]        w_inst;
    dec_t               w_dec;
    logic [REG_AW-1:0]  w_rs, w_rt, w_rd, w_wr_addr;
    logic [DATA_W-1:0]  w_fwd1, w_fwd2, w_imm_sext, w_op1, w_op2;
    logic [PC_W-1:0]    w_br_off, w_br_target;
    logic               w_wr_en, w_br_taken, w_stall, w_in_ready, w_accept;

    logic               r_valid, r_wr_en, r_mem_rd, r_mem_wr, r_br_taken, r_illegal;
    logic [ALUOP_W-1:0] r_alu_op;
    logic [DATA_W-1:0]  r_op1, r_op2, r_st_data;
    logic [REG_AW-1:0]  r_wr_addr;
    logic [PC_W-1:0]    r_br_target;

    // Register 0 reads as zero; the younger EX result beats MEM.
    function automatic logic [DATA_W-1:0] f_forward(
        input logic [REG_AW-1:0] addr,     input logic [DATA_W-1:0] rf_data,
        input logic              ex_en,    input logic [REG_AW-1:0] ex_addr,
        input logic [DATA_W-1:0] ex_data,  input logic              mem_en,
        input logic [REG_AW-1:0] mem_addr, input logic [DATA_W-1:0] mem_data);
        if (addr == '0)                        return '0;
        else if (ex_en && ex_addr == addr)     return ex_data;
        else if (mem_en && mem_addr == addr)   return mem_data;
        else                                   return rf_data;
    endfunction

    assign w_inst = bus.in_inst;
    assign w_rs   = REG_AW'(w_inst[25:21]);
    assign w_rt   = REG_AW'(w_inst[20:16]);
    assign w_rd   = REG_AW'(w_inst[15:11]);

    id_stage_pipe_decoder u_decoder (
        .i_opcode (w_inst[31:26]),
        .i_funct  (w_inst[5:0]),
        .o_dec    (w_dec)
    );

    assign w_fwd1 = f_forward(w_rs, bus.rd_data1, bus.ex_wr_en, bus.ex_wr_addr, bus.ex_wr_data,
                              bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data);
    assign w_fwd2 = f_forward(w_rt, bus.rd_data2, bus.ex_wr_en, bus.ex_wr_addr, bus.ex_wr_data,
                              bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data);

    assign w_imm_sext = {{(DATA_W-16){w_inst[15]}}, w_inst[15:0]};

    always_comb begin
        w_op1 = '0;
        if (w_dec.shift)       w_op1 = DATA_W'(w_inst[10:6]);
        else if (w_dec.rd_en1) w_op1 = w_fwd1;
    end

    always_comb begin
        w_op2 = '0;
        case (w_dec.imm_sel)
            IMM_SEXT: w_op2 = w_imm_sext;
            IMM_ZEXT: w_op2 = DATA_W'(w_inst[15:0]);
            IMM_LUI:  w_op2 = DATA_W'({w_inst[15:0], 16'h0000});
            default:  w_op2 = w_dec.rd_en2 ? w_fwd2 : '0;
        endcase
    end

    always_comb begin
        w_wr_addr = '0;
        case (w_dec.wr_sel)
            WR_RD:   w_wr_addr = w_rd;
            WR_RT:   w_wr_addr = w_rt;
            default: w_wr_addr = '0;
        endcase
    end

    assign w_wr_en     = (w_dec.wr_sel != WR_NONE) && (w_wr_addr != '0);
    assign w_br_off    = {{(PC_W-18){w_inst[15]}}, w_inst[15:0], 2'b00};
    assign w_br_target = bus.in_pc + PC_W'(4) + w_br_off;
    assign w_br_taken  = (w_dec.br_eq && (w_fwd1 == w_fwd2)) ||
                         (w_dec.br_ne && (w_fwd1 != w_fwd2));

    // A load in EX has no data yet; any consumer of its destination waits.
    assign w_stall = bus.ex_wr_en && bus.ex_is_load && (bus.ex_wr_addr != '0) &&
                     ((w_dec.rd_en1 && (w_rs == bus.ex_wr_addr)) ||
                      (w_dec.rd_en2 && (w_rt == bus.ex_wr_addr)));

    assign w_in_ready = !rst && !bus.flush && !w_stall && (!r_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_alu_op    <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_st_data   <= '0;
            r_wr_addr   <= '0;
            r_wr_en     <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
            r_illegal   <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_alu_op    <= ALUOP_W'(w_dec.alu_op);
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_st_data   <= w_dec.mem_wr ? w_fwd2 : '0;
            r_wr_addr   <= w_wr_addr;
            r_wr_en     <= w_wr_en;
            r_mem_rd    <= w_dec.mem_rd;
            r_mem_wr    <= w_dec.mem_wr;
            r_br_taken  <= w_br_taken;
            r_br_target <= w_br_target;
            r_illegal   <= w_dec.illegal;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.rd_addr1      = w_rs;
    assign bus.rd_addr2      = w_rt;
    assign bus.rd_en1        = w_dec.rd_en1;
    assign bus.rd_en2        = w_dec.rd_en2;
    assign bus.out_valid     = r_valid;
    assign bus.out_alu_op    = r_alu_op;
    assign bus.out_op1       = r_op1;
    assign bus.out_op2       = r_op2;
    assign bus.out_st_data   = r_st_data;
    assign bus.out_wr_addr   = r_wr_addr;
    assign bus.out_wr_en     = r_wr_en;
    assign bus.out_mem_rd    = r_mem_rd;
    assign bus.out_mem_wr    = r_mem_wr;
    assign bus.out_br_taken  = r_br_taken;
    assign bus.out_br_target = r_br_target;
    assign bus.out_illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
//==============================================================================
// Module      : tb_id_stage_pipe
// Description : Self-checking bench for id_stage_pipe. An instruction-level
//               model predicts the ID/EX register and handshake every cycle;
//               directed vectors carry hand-computed literal expectations.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_id_stage_pipe;
    import id_stage_pipe_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [3:0]  alu_op;
        logic [31:0] op1, op2, st_data;
        logic [4:0]  wr_addr;
        logic        wr_en, mem_rd, mem_wr, br_taken;
        logic [31:0] br_target;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rf [32];
    exp_t        m;
    logic        m_acc   = 1'b0;
    logic        started = 1'b0;
    int          n_pass  = 0;
    int          n_total = 0;

    id_stage_pipe_if bus ();

    id_stage_pipe dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.rd_data1 = rf[bus.rd_addr1];
    assign bus.rd_data2 = rf[bus.rd_addr2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // {reads rs, reads rt} for an instruction word
    function automatic logic [1:0] uses(input logic [31:0] inst);
        case (inst[31:26])
            6'h00: case (inst[5:0])
                6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A: return 2'b11;
                6'h00, 6'h02:                             return 2'b01;
                default:                                  return 2'b00;
            endcase
            6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23: return 2'b10;
            6'h2B, 6'h04, 6'h05:                      return 2'b11;
            default:                                  return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (bus.ex_wr_en && bus.ex_wr_addr == r) return bus.ex_wr_data;
        if (bus.mem_wr_en && bus.mem_wr_addr == r) return bus.mem_wr_data;
        return rf[r];
    endfunction

    function automatic logic m_ready();
        logic [1:0] u;
        logic       stall;
        u = uses(bus.in_inst);
        stall = bus.ex_wr_en && bus.ex_is_load && bus.ex_wr_addr != 5'd0 &&
                ((u[1] && bus.in_inst[25:21] == bus.ex_wr_addr) ||
                 (u[0] && bus.in_inst[20:16] == bus.ex_wr_addr));
        return !rst && !bus.flush && !stall && (!m.valid || bus.out_ready);
    endfunction

    function automatic exp_t predict(input logic [31:0] inst, input logic [31:0] pc);
        exp_t        e;
        logic [31:0] a, b, s, z;
        logic [4:0]  rt, rd, dst;
        rt = inst[20:16];
        rd = inst[15:11];
        s  = {{16{inst[15]}}, inst[15:0]};
        z  = {16'h0, inst[15:0]};
        a  = fwd(inst[25:21]);
        b  = fwd(rt);
        e  = '0;
        e.valid     = 1'b1;
        e.alu_op    = ALU_ADD;
        e.br_target = pc + 32'd4 + (s << 2);
        dst = 5'd0;
        case (inst[31:26])
            6'h00: case (inst[5:0])
                6'h21: begin e.alu_op = ALU_ADD; e.op1 = a; e.op2 = b; dst = rd; end
                6'h23: begin e.alu_op = ALU_SUB; e.op1 = a; e.op2 = b; dst = rd; end
                6'h24: begin e.alu_op = ALU_AND; e.op1 = a; e.op2 = b; dst = rd; end
                6'h25: begin e.alu_op = ALU_OR;  e.op1 = a; e.op2 = b; dst = rd; end
                6'h26: begin e.alu_op = ALU_XOR; e.op1 = a; e.op2 = b; dst = rd; end
                6'h2A: begin e.alu_op = ALU_SLT; e.op1 = a; e.op2 = b; dst = rd; end
                6'h00: begin e.alu_op = ALU_SLL; e.op1 = {27'd0, inst[10:6]}; e.op2 = b; dst = rd; end
                6'h02: begin e.alu_op = ALU_SRL; e.op1 = {27'd0, inst[10:6]}; e.op2 = b; dst = rd; end
                default: e.illegal = 1'b1;
            endcase
            6'h09: begin e.op1 = a; e.op2 = s; dst = rt; end
            6'h0A: begin e.alu_op = ALU_SLT; e.op1 = a; e.op2 = s; dst = rt; end
            6'h0C: begin e.alu_op = ALU_AND; e.op1 = a; e.op2 = z; dst = rt; end
            6'h0D: begin e.alu_op = ALU_OR;  e.op1 = a; e.op2 = z; dst = rt; end
            6'h0E: begin e.alu_op = ALU_XOR; e.op1 = a; e.op2 = z; dst = rt; end
            6'h0F: begin e.op2 = {inst[15:0], 16'h0}; dst = rt; end
            6'h23: begin e.op1 = a; e.op2 = s; dst = rt; e.mem_rd = 1'b1; end
            6'h2B: begin e.op1 = a; e.op2 = s; e.st_data = b; e.mem_wr = 1'b1; end
            6'h04: begin e.alu_op = ALU_SUB; e.op1 = a; e.op2 = b; e.br_taken = (a == b); end
            6'h05: begin e.alu_op = ALU_SUB; e.op1 = a; e.op2 = b; e.br_taken = (a != b); end
            default: e.illegal = 1'b1;
        endcase
        e.wr_addr = dst;
        e.wr_en   = (dst != 5'd0);
        return e;
    endfunction

    // Model of the ID/EX register
    always @(posedge clk) begin
        m_acc <= 1'b0;
        if (rst) begin
            m       <= '0;
            started <= 1'b1;
        end else if (bus.flush) begin
            m.valid <= 1'b0;
        end else if (bus.in_valid && m_ready()) begin
            m     <= predict(bus.in_inst, bus.in_pc);
            m_acc <= 1'b1;
        end else if (bus.out_ready) begin
            m.valid <= 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            check("out_valid",     bus.out_valid,     m.valid);
            check("out_alu_op",    bus.out_alu_op,    m.alu_op);
            check("out_op1",       bus.out_op1,       m.op1);
            check("out_op2",       bus.out_op2,       m.op2);
            check("out_st_data",   bus.out_st_data,   m.st_data);
            check("out_wr_addr",   bus.out_wr_addr,   m.wr_addr);
            check("out_wr_en",     bus.out_wr_en,     m.wr_en);
            check("out_mem_rd",    bus.out_mem_rd,    m.mem_rd);
            check("out_mem_wr",    bus.out_mem_wr,    m.mem_wr);
            check("out_br_taken",  bus.out_br_taken,  m.br_taken);
            check("out_br_target", bus.out_br_target, m.br_target);
            check("out_illegal",   bus.out_illegal,   m.illegal);
            check("in_ready",      bus.in_ready,      m_ready());
            check("rd_addr1",      bus.rd_addr1,      bus.in_inst[25:21]);
            check("rd_addr2",      bus.rd_addr2,      bus.in_inst[20:16]);
            check("rd_en",         {bus.rd_en1, bus.rd_en2}, uses(bus.in_inst));
        end
    end

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (m_acc) break;
        end
        if (!m_acc) begin
            n_total++;
            $display("FAIL accept_timeout: inst %h not accepted within 8 cycles", inst);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] c_MISC [10] = '{
        32'h0043582A, 32'h00646024, 32'h00646825, 32'h00647026, 32'h000307C2,
        32'h2870FFFB, 32'h30718001, 32'h3C071234, 32'h00220021, 32'h8C2A0004
    };

    initial begin
        logic [31:0] inst;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[0] = 32'hDEADBEEF;   // must never reach an operand
        rf[1] = 32'd7;
        rf[2] = 32'd7;
        rf[3] = 32'hFFFFFFF0;
        rst = 1'b1;
        bus.in_valid = 0; bus.in_inst = 0; bus.in_pc = 0;
        bus.ex_wr_en = 0; bus.ex_wr_addr = 0; bus.ex_wr_data = 0; bus.ex_is_load = 0;
        bus.mem_wr_en = 0; bus.mem_wr_addr = 0; bus.mem_wr_data = 0;
        bus.flush = 0; bus.out_ready = 1;

        // Reset
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready",  bus.in_ready,  0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Sign- vs zero-extended immediates
        issue(32'h24018000, 32'h0);   // ADDIU r1,r0,0x8000
        @(negedge clk);
        check("addiu_op1", bus.out_op1, 32'h0);
        check("addiu_op2", bus.out_op2, 32'hFFFF8000);
        check("addiu_wr",  {bus.out_wr_addr, bus.out_wr_en}, {5'd1, 1'b1});
        issue(32'h34018000, 32'h4);   // ORI r1,r0,0x8000
        @(negedge clk);
        check("ori_op2", bus.out_op2, 32'h00008000);

        // EX beats MEM on the same register
        bus.ex_wr_en = 1; bus.ex_wr_addr = 3; bus.ex_wr_data = 32'hAA;
        bus.mem_wr_en = 1; bus.mem_wr_addr = 3; bus.mem_wr_data = 32'hBB;
        issue(32'h00632021, 32'h8);   // ADDU r4,r3,r3
        @(negedge clk);
        check("fwd_ex_op1", bus.out_op1, 32'hAA);
        check("fwd_ex_op2", bus.out_op2, 32'hAA);
        bus.ex_wr_en = 0;
        issue(32'h00632023, 32'hC);   // SUBU r4,r3,r3
        @(negedge clk);
        check("fwd_mem_op1", bus.out_op1, 32'hBB);
        bus.mem_wr_en = 0;
        issue(32'h00022900, 32'h10);  // SLL r5,r2,4
        @(negedge clk);
        check("sll_ops", {bus.out_op1, bus.out_op2}, {32'd4, 32'd7});

        // Load-use stall, then accept once the load result forwards from EX
        #1;
        bus.ex_wr_en = 1; bus.ex_wr_addr = 5; bus.ex_wr_data = 32'h55; bus.ex_is_load = 1;
        bus.in_valid = 1; bus.in_inst = 32'h00A23023; bus.in_pc = 32'h14;
        @(negedge clk);
        check("stall_in_ready", bus.in_ready, 0);
        @(negedge clk);
        check("stall_bubble", bus.out_valid, 0);
        check("stall_in_ready2", bus.in_ready, 0);
        bus.ex_is_load = 0;
        issue(32'h00A23023, 32'h14);
        @(negedge clk);
        check("after_stall_op1", bus.out_op1, 32'h55);
        bus.ex_wr_en = 0;

        // Backpressure holds the register
        issue(32'h342800FF, 32'h18);  // ORI r8,r1,0xFF
        bus.out_ready = 0;
        bus.in_valid = 1; bus.in_inst = 32'h3849F0F0; bus.in_pc = 32'h1C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_op2", bus.out_op2, 32'hFF);
        end
        bus.out_ready = 1;
        issue(32'h3849F0F0, 32'h1C);  // XORI r9,r2,0xF0F0
        @(negedge clk);
        check("release_ops", {bus.out_op1, bus.out_op2}, {32'd7, 32'h0000F0F0});

        // Branches resolved in ID
        issue(32'h1022FFFF, 32'h100); // BEQ r1,r2,-1
        @(negedge clk);
        check("beq_taken",  bus.out_br_taken, 1);
        check("beq_target", bus.out_br_target, 32'h100);
        rf[2] = 32'd8;
        issue(32'h1022FFFF, 32'h100);
        @(negedge clk);
        check("beq_not_taken", bus.out_br_taken, 0);
        issue(32'h1422FFFF, 32'h200); // BNE r1,r2,-1
        @(negedge clk);
        check("bne_taken", bus.out_br_taken, 1);
        issue(32'hAC2AFFF8, 32'h204); // SW r10,-8(r1)
        @(negedge clk);
        check("sw_fields", {bus.out_st_data, bus.out_op2, bus.out_mem_wr, bus.out_wr_en},
              {32'h100A, 32'hFFFFFFF8, 1'b1, 1'b0});

        // Assorted encodings, model-checked
        for (int i = 0; i < 10; i++) begin
            inst = c_MISC[i];
            issue(inst, 32'h300 + 32'(i * 4));
        end
        @(negedge clk);
        check("lw_mem_rd", bus.out_mem_rd, 1);
        issue(32'h00220021, 32'h400); // ADDU r0,r1,r2
        @(negedge clk);
        check("r0_wr_en", bus.out_wr_en, 0);
        issue(32'hFC000000, 32'h404); // bad opcode
        @(negedge clk);
        check("illegal_op", {bus.out_illegal, bus.out_wr_en}, {1'b1, 1'b0});
        issue(32'h0000003F, 32'h408); // bad funct
        @(negedge clk);
        check("illegal_fn", bus.out_illegal, 1);

        // Flush blocks acceptance and empties the register
        #1;
        bus.flush = 1; bus.in_valid = 1; bus.in_inst = 32'h24050011; bus.in_pc = 32'h500;
        @(negedge clk);
        check("flush_in_ready", bus.in_ready, 0);
        @(negedge clk);
        check("flush_out_valid", bus.out_valid, 0);
        bus.flush = 0;
        issue(32'h24050011, 32'h500); // ADDIU r5,r0,0x11
        @(negedge clk);
        check("post_flush_op2", bus.out_op2, 32'h11);

        // Reset mid-stream
        rst = 1;
        @(negedge clk);
        check("rst2_valid", bus.out_valid, 0);
        check("rst2_ops", {bus.out_op1, bus.out_op2, bus.out_br_target}, 96'h0);
        check("rst2_wr", {bus.out_wr_addr, bus.out_wr_en}, 6'h0);
        rst = 0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
